// File: rtl/cte_pkg.sv
// Shared definitions for the CTE colour-transform stage.
// Holds the input-FSM and output-beat encodings, the fixed-point colour
// coefficients (8 fraction bits), the rounding offsets, the clip bounds
// and a small saturating clip helper used by the arithmetic block.
package cte_pkg;

    typedef enum logic [1:0] {
        IN_P0   = 2'd0,
        IN_P1   = 2'd1,
        IN_FULL = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        BEAT_U  = 2'd0,
        BEAT_Y0 = 2'd1,
        BEAT_V  = 2'd2,
        BEAT_Y1 = 2'd3
    } beat_t;

    // Width of the signed intermediates; wide enough that no sum of
    // products overflows before clipping.
    localparam int MATH_W = 20;

    // Luma coefficients
    localparam logic signed [MATH_W-1:0] C_YR =  20'sd77;
    localparam logic signed [MATH_W-1:0] C_YG =  20'sd150;
    localparam logic signed [MATH_W-1:0] C_YB =  20'sd29;
    // U coefficients (applied to pair sums)
    localparam logic signed [MATH_W-1:0] C_UR = -20'sd43;
    localparam logic signed [MATH_W-1:0] C_UG = -20'sd85;
    localparam logic signed [MATH_W-1:0] C_UB =  20'sd128;
    // V coefficients (applied to pair sums)
    localparam logic signed [MATH_W-1:0] C_VR =  20'sd128;
    localparam logic signed [MATH_W-1:0] C_VG = -20'sd107;
    localparam logic signed [MATH_W-1:0] C_VB = -20'sd21;

    // Half-LSB offsets: luma shifts by 8, chroma by 9 (pair sum halves it)
    localparam logic signed [MATH_W-1:0] RND_Y = 20'sd128;
    localparam logic signed [MATH_W-1:0] RND_C = 20'sd256;

    // Clip bounds
    localparam logic signed [MATH_W-1:0] Y_MIN =  20'sd0;
    localparam logic signed [MATH_W-1:0] Y_MAX =  20'sd255;
    localparam logic signed [MATH_W-1:0] C_MIN = -20'sd128;
    localparam logic signed [MATH_W-1:0] C_MAX =  20'sd127;

    function automatic logic signed [MATH_W-1:0] clip(
        input logic signed [MATH_W-1:0] x,
        input logic signed [MATH_W-1:0] lo,
        input logic signed [MATH_W-1:0] hi
    );
        if (x < lo)      return lo;
        else if (x > hi) return hi;
        else             return x;
    endfunction

endpackage

// File: rtl/rgb_pair_yuv_math.sv
// Purely combinational RGB-pair to YUV 4:2:2 arithmetic.
// Ports:
//   pix0_i, pix1_i : {R,G,B} unsigned 8-bit channels of the stored pair
//   u_o, v_o       : chroma from the pair sums, two's complement, clipped
//   y0_o, y1_o     : per-pixel luma, unsigned, clipped
module rgb_pair_yuv_math
    import cte_pkg::*;
#(
    parameter int COEF_FRAC = 8,
    parameter int OUT_W     = 8
) (
    input  logic [23:0]      pix0_i,
    input  logic [23:0]      pix1_i,
    output logic [OUT_W-1:0] u_o,
    output logic [OUT_W-1:0] y0_o,
    output logic [OUT_W-1:0] v_o,
    output logic [OUT_W-1:0] y1_o
);

    logic signed [MATH_W-1:0] r0, g0, b0, r1, g1, b1;
    logic signed [MATH_W-1:0] rs, gs, bs;
    logic signed [MATH_W-1:0] y0_w, y1_w, u_w, v_w;

    assign r0 = MATH_W'(pix0_i[23:16]);
    assign g0 = MATH_W'(pix0_i[15:8]);
    assign b0 = MATH_W'(pix0_i[7:0]);
    assign r1 = MATH_W'(pix1_i[23:16]);
    assign g1 = MATH_W'(pix1_i[15:8]);
    assign b1 = MATH_W'(pix1_i[7:0]);

    assign rs = r0 + r1;
    assign gs = g0 + g1;
    assign bs = b0 + b1;

    assign y0_w = (C_YR * r0 + C_YG * g0 + C_YB * b0 + RND_Y) >>> COEF_FRAC;
    assign y1_w = (C_YR * r1 + C_YG * g1 + C_YB * b1 + RND_Y) >>> COEF_FRAC;

    // Pair sums carry one extra bit, so chroma shifts one further to average.
    assign u_w = (C_UR * rs + C_UG * gs + C_UB * bs + RND_C) >>> (COEF_FRAC + 1);
    assign v_w = (C_VR * rs + C_VG * gs + C_VB * bs + RND_C) >>> (COEF_FRAC + 1);

    assign y0_o = OUT_W'(clip(y0_w, Y_MIN, Y_MAX));
    assign y1_o = OUT_W'(clip(y1_w, Y_MIN, Y_MAX));
    assign u_o  = OUT_W'(clip(u_w, C_MIN, C_MAX));
    assign v_o  = OUT_W'(clip(v_w, C_MIN, C_MAX));

endmodule

// File: rtl/rgb_to_yuv.sv
// Forward colour transform: 24-bit RGB pixel stream in, 8-bit 4:2:2
// byte stream out in the order U, Y0, V, Y1 (one byte per cycle).
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_en     : rgb_in valid; accepted on an edge with in_en=1 and busy=0
//   rgb_in    : {R[23:16], G[15:8], B[7:0]}
//   busy      : current rgb_in is not accepted this cycle
//   out_valid : yuv_out holds a valid byte
//   yuv_out   : current output byte (U/V signed, Y unsigned)
module rgb_to_yuv
    import cte_pkg::*;
#(
    parameter int COEF_FRAC = 8,
    parameter int OUT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [23:0]      rgb_in,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] yuv_out
);

    in_state_t        state_q, state_d;
    beat_t            beat_q, beat_d;
    logic             active_q, active_d;
    logic [23:0]      pix0_q, pix1_q;
    logic [OUT_W-1:0] u_q, y0_q, v_q, y1_q;
    logic [OUT_W-1:0] u_w, y0_w, v_w, y1_w;

    logic transfer;
    logic accept;
    logic load_p0;
    logic load_p1;

    rgb_pair_yuv_math #(
        .COEF_FRAC (COEF_FRAC),
        .OUT_W     (OUT_W)
    ) u_math (
        .pix0_i (pix0_q),
        .pix1_i (pix1_q),
        .u_o    (u_w),
        .y0_o   (y0_w),
        .v_o    (v_w),
        .y1_o   (y1_w)
    );

    // Input FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IN_P0;
        else        state_q <= state_d;
    end

    // Input FSM: next state. A transfer frees the pair slot in the same
    // edge, so a pixel accepted then is pixel 0 of the next pair.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IN_P0:   if (accept)   state_d = IN_P1;
            IN_P1:   if (accept)   state_d = IN_FULL;
            IN_FULL: if (transfer) state_d = accept ? IN_P1 : IN_P0;
            default:               state_d = IN_P0;
        endcase
    end

    // Input FSM: outputs / handshake
    always_comb begin
        transfer = (state_q == IN_FULL) && (!active_q || (beat_q == BEAT_Y1));
        busy     = (state_q == IN_FULL) && !transfer;
        accept   = in_en && !busy;
        load_p0  = accept && (state_q != IN_P1);
        load_p1  = accept && (state_q == IN_P1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix0_q <= '0;
            pix1_q <= '0;
        end else begin
            if (load_p0) pix0_q <= rgb_in;
            if (load_p1) pix1_q <= rgb_in;
        end
    end

    // Output beat sequencing; beat stays at Y1 after the burst so the
    // last byte keeps showing while idle.
    always_comb begin
        active_d = active_q;
        beat_d   = beat_q;
        if (transfer) begin
            active_d = 1'b1;
            beat_d   = BEAT_U;
        end else if (active_q) begin
            if (beat_q == BEAT_Y1) active_d = 1'b0;
            else                   beat_d   = beat_t'(beat_q + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            beat_q   <= BEAT_U;
            u_q      <= '0;
            y0_q     <= '0;
            v_q      <= '0;
            y1_q     <= '0;
        end else begin
            active_q <= active_d;
            beat_q   <= beat_d;
            if (transfer) begin
                u_q  <= u_w;
                y0_q <= y0_w;
                v_q  <= v_w;
                y1_q <= y1_w;
            end
        end
    end

    assign out_valid = active_q;

    always_comb begin
        yuv_out = u_q;
        unique case (beat_q)
            BEAT_U:  yuv_out = u_q;
            BEAT_Y0: yuv_out = y0_q;
            BEAT_V:  yuv_out = v_q;
            BEAT_Y1: yuv_out = y1_q;
            default: yuv_out = u_q;
        endcase
    end

endmodule

// File: tb/tb_rgb_to_yuv.sv
// Self-checking bench for rgb_to_yuv: directed colour pairs, randomized
// pairs and streams against a behavioural reference, reset aborts and a
// grey loopback through a software YUV->RGB decode.
module tb_rgb_to_yuv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_en = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        busy;
    logic        out_valid;
    logic [7:0]  yuv_out;

    always #5 clk = ~clk;

    rgb_to_yuv #(
        .COEF_FRAC (8),
        .OUT_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .rgb_in    (rgb_in),
        .busy      (busy),
        .out_valid (out_valid),
        .yuv_out   (yuv_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    int          vcyc_q[$];
    logic [23:0] pix_q[$];
    bit          busy_log[$];
    bit          model_on = 1'b0;
    bit          log_busy = 1'b0;
    int          seen_cnt = 0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Round-half-up division: floor((num + den/2) / den)
    function automatic int rnd_div(input int num, input int den);
        return int'($floor((real'(num) + real'(den) / 2.0) / real'(den)));
    endfunction

    function automatic int luma(input logic [23:0] p);
        return clampi(rnd_div(77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]), 256), 0, 255);
    endfunction

    task automatic model_pair(input logic [23:0] p0, input logic [23:0] p1);
        int rs, gs, bs, u, v;
        rs = int'(p0[23:16]) + int'(p1[23:16]);
        gs = int'(p0[15:8])  + int'(p1[15:8]);
        bs = int'(p0[7:0])   + int'(p1[7:0]);
        u  = clampi(rnd_div(-43 * rs - 85 * gs + 128 * bs, 512), -128, 127);
        v  = clampi(rnd_div(128 * rs - 107 * gs - 21 * bs, 512), -128, 127);
        exp_q.push_back(8'(u));
        exp_q.push_back(8'(luma(p0)));
        exp_q.push_back(8'(v));
        exp_q.push_back(8'(luma(p1)));
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset && out_valid) begin
            cap_q.push_back(yuv_out);
            vcyc_q.push_back(cyc);
            seen_cnt++;
            check("byte_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("yuv_byte", yuv_out, exp_q.pop_front());
        end
    end

    // ---------------- drivers (called at a negedge) ----------------
    task automatic send_pixel(input logic [23:0] p);
        int n;
        n = 0;
        rgb_in = p;
        in_en  = 1'b1;
        while (busy && n < 40) begin
            if (log_busy) busy_log.push_back(busy);
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 32'(busy), 0);
        if (log_busy) busy_log.push_back(busy);
        @(posedge clk);
        pix_q.push_back(p);
        if (pix_q.size() == 2) begin
            if (model_on) model_pair(pix_q[0], pix_q[1]);
            pix_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        in_en = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
        idle(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, vbase, n;
        int y, u, v, r_rec, g_rec, b_rec;

        // Reset for 3 cycles
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_yuv", yuv_out, 0);
        reset = 1'b1;
        idle(20);
        check("idle_busy", busy, 0);
        check("idle_no_output", seen_cnt, 0);

        // White pair: also checks U appears one cycle after pixel 1 accept
        model_on = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        send_pixel(24'hFFFFFF);
        send_pixel(24'hFFFFFF);
        in_en = 1'b0;
        check("white_lat_pre", out_valid, 0);
        @(negedge clk);
        check("white_lat_U", out_valid, 1);
        wait_drain();

        // Red pair
        exp_q.push_back(8'hD5); exp_q.push_back(8'h4D);
        exp_q.push_back(8'h7F); exp_q.push_back(8'h4D);
        send_pixel(24'hFF0000);
        send_pixel(24'hFF0000);
        wait_drain();

        // Blue pair
        exp_q.push_back(8'h7F); exp_q.push_back(8'h1D);
        exp_q.push_back(8'hEB); exp_q.push_back(8'h1D);
        send_pixel(24'h0000FF);
        send_pixel(24'h0000FF);
        wait_drain();

        // Randomized pairs with random gaps, model-checked
        model_on = 1'b1;
        repeat (6) begin
            send_pixel(24'($urandom));
            idle($urandom_range(0, 3));
            send_pixel(24'($urandom));
            idle($urandom_range(0, 3));
        end
        wait_drain();

        // Stall: 5-cycle gap between pixel 0 and pixel 1
        send_pixel(24'($urandom));
        idle(5);
        send_pixel(24'($urandom));
        wait_drain();

        // Back-to-back stream of 8 pixels
        vbase = vcyc_q.size();
        busy_log.delete();
        log_busy = 1'b1;
        for (int i = 0; i < 8; i++) send_pixel(24'($urandom));
        log_busy = 1'b0;
        wait_drain();
        check("stream_log_len", 32'(busy_log.size()), 12);
        for (int i = 0; i < busy_log.size(); i++)
            check($sformatf("stream_busy[%0d]", i), 32'(busy_log[i]),
                  32'((i >= 2) && (((i - 2) % 4) >= 2)));
        check("stream_valid_cnt", 32'(vcyc_q.size() - vbase), 16);
        if (vcyc_q.size() - vbase == 16)
            check("stream_contig", 32'(vcyc_q[vbase + 15] - vcyc_q[vbase] + 1), 16);

        // Reset mid-pair: pixel 0 must be discarded
        send_pixel(24'h123456);
        in_en = 1'b0;
        #2 reset = 1'b0;
        #1 check("midpair_rst_busy", busy, 0);
        pix_q.delete();
        @(negedge clk);
        reset = 1'b1;
        send_pixel(24'($urandom));
        send_pixel(24'($urandom));
        wait_drain();

        // Reset during beat V
        base = seen_cnt;
        send_pixel(24'($urandom));
        send_pixel(24'($urandom));
        in_en = 1'b0;
        n = 0;
        while (seen_cnt != base + 3 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_beat_v", seen_cnt - base, 3);
        #1 reset = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_yuv", yuv_out, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        pix_q.delete();
        @(negedge clk);
        reset = 1'b1;
        send_pixel(24'($urandom));
        send_pixel(24'($urandom));
        wait_drain();

        // Grey loopback through a software decoder
        base = cap_q.size();
        send_pixel(24'h808080);
        send_pixel(24'h808080);
        wait_drain();
        check("loop_bytes", 32'(cap_q.size() - base), 4);
        if (cap_q.size() - base == 4) begin
            u = int'($signed(cap_q[base]));
            y = int'(cap_q[base + 1]);
            v = int'($signed(cap_q[base + 2]));
            r_rec = int'(real'(y) + 1.402 * real'(v));
            g_rec = int'(real'(y) - 0.344 * real'(u) - 0.714 * real'(v));
            b_rec = int'(real'(y) + 1.772 * real'(u));
            check("loop_r", 32'((r_rec >= 126) && (r_rec <= 130)), 1);
            check("loop_g", 32'((g_rec >= 126) && (g_rec <= 130)), 1);
            check("loop_b", 32'((b_rec >= 126) && (b_rec <= 130)), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
